// File: rtl/instr_enc_pkg.sv
// ---------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the RV32I instruction encoder/loader:
//   - major opcode constants
//   - canonical NOP word (addi x0,x0,0)
//   - instruction format enum, loader FSM state enum
//   - field bundle struct carried through the loader pipeline
//   - opcode_fmt(): maps a major opcode to its encoding format
// ---------------------------------------------------------------------------
package instr_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f30;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } instr_fields_t;

    function automatic fmt_t opcode_fmt(input logic [6:0] op);
        case (op)
            OP_R:                         return FMT_R;
            OP_I, OP_LOAD, OP_JALR,
            OP_SYS:                       return FMT_I;
            OP_STORE:                     return FMT_S;
            OP_BRANCH:                    return FMT_B;
            OP_LUI, OP_AUIPC:             return FMT_U;
            OP_JAL:                       return FMT_J;
            default:                      return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/instr_fmt_enc.sv
// ---------------------------------------------------------------------------
// instr_fmt_enc
// Purely combinational RV32I field bundle -> 32-bit instruction word.
// Unknown opcodes encode as NOP_WORD.
//
// Build option ENC_ILLEGAL_CHK_EN:
//   defined   - illegal_o flags unknown opcodes, misaligned B/J offsets and
//               out-of-range immediates; flagged words are replaced by NOP.
//   undefined - illegal_o tied 0, oversize immediates are truncated.
//
// Ports:
//   fields_i   in  instr_fields_t  opcode/funct3/f30/rd/rs1/rs2/imm
//   word_o     out 32              encoded instruction
//   illegal_o  out 1               encode error (always 0 without the option)
// ---------------------------------------------------------------------------
module instr_fmt_enc
    import instr_enc_pkg::*;
(
    input  instr_fields_t fields_i,
    output logic [31:0]   word_o,
    output logic          illegal_o
);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm;
    fmt_t        fmt;
    logic [11:0] i_imm;
    logic [31:0] raw_word;

    assign op  = fields_i.opcode;
    assign f3  = fields_i.funct3;
    assign imm = fields_i.imm;
    assign fmt = opcode_fmt(op);

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        i_imm    = imm[11:0];
        raw_word = NOP_WORD;
        case (fmt)
            FMT_R: raw_word = {1'b0, fields_i.f30, 5'b00000, fields_i.rs2,
                               fields_i.rs1, f3, fields_i.rd, op};
            FMT_I: begin
                // Immediate shifts carry the SRA/SRL selector in imm[10].
                if (op == OP_I && (f3 == 3'b001 || f3 == 3'b101)) begin
                    i_imm = {1'b0, fields_i.f30, 5'b00000, imm[4:0]};
                end
                raw_word = {i_imm, fields_i.rs1, f3, fields_i.rd, op};
            end
            FMT_S: raw_word = {imm[11:5], fields_i.rs2, fields_i.rs1, f3,
                               imm[4:0], op};
            FMT_B: raw_word = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1,
                               f3, imm[4:1], imm[11], op};
            FMT_U: raw_word = {imm[31:12], fields_i.rd, op};
            FMT_J: raw_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                               fields_i.rd, op};
            default: raw_word = NOP_WORD;
        endcase
    end

`ifdef ENC_ILLEGAL_CHK_EN
    logic illegal;

    // Range checks: all bits above the field's sign bit must replicate it.
    always_comb begin
        illegal = 1'b0;
        case (fmt)
            FMT_I, FMT_S: illegal = (imm[31:11] != {21{imm[11]}});
            FMT_B:        illegal = (imm[31:12] != {20{imm[12]}}) | imm[0];
            FMT_J:        illegal = (imm[31:20] != {12{imm[20]}}) | imm[0];
            FMT_BAD:      illegal = 1'b1;
            default:      illegal = 1'b0;
        endcase
    end

    assign word_o    = illegal ? NOP_WORD : raw_word;
    assign illegal_o = illegal;
`else
    assign word_o    = raw_word;
    assign illegal_o = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
// Accepts RV32I field bundles over a valid/ready stream, encodes them and
// writes the words sequentially into instruction memory starting at
// BASE_ADDR. Two-stage pipeline: S1 holds accepted fields, S2 drives MEM_*.
// START flushes both stages and begins a new session; a session stops
// accepting once DEPTH words are written or in flight.
//
// Build option ENC_ILLEGAL_CHK_EN enables the sticky encode error (err_o);
// without it err_o stays 0.
//
// Ports:
//   clk_i          in  1       clock, rising edge
//   rst_i          in  1       synchronous active-high reset
//   start_i        in  1       begin/restart a load session
//   in_valid_i     in  1       field bundle valid
//   in_ready_o     out 1       bundle accepted when valid & ready
//   in_opcode_i    in  7       major opcode
//   in_funct3_i    in  3       funct3
//   in_f30_i       in  1       instruction bit 30
//   in_rd_i        in  5       destination register
//   in_rs1_i       in  5       source register 1
//   in_rs2_i       in  5       source register 2
//   in_imm_i       in  32      sign-extended immediate
//   mem_we_o       out 1       write strobe, held until mem_ready_i
//   mem_addr_o     out ADDR_W  byte address of the write
//   mem_wdata_o    out 32      encoded instruction
//   mem_ready_i    in  1       memory accepts the write this cycle
//   word_cnt_o     out 11      words written this session
//   full_o         out 1       DEPTH words written
//   err_o          out 1       sticky encode error
// ---------------------------------------------------------------------------
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int                 ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int                 DEPTH     = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        in_opcode_i,
    input  logic [2:0]        in_funct3_i,
    input  logic              in_f30_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [31:0]       in_imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic [10:0]       word_cnt_o,
    output logic              full_o,
    output logic              err_o
);

    localparam logic [10:0] DEPTH_C = 11'(DEPTH);

    state_t              state_q, state_d;
    logic                s1_valid_q, s1_valid_d;
    instr_fields_t       s1_fields_q, s1_fields_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [10:0]         word_cnt_q, word_cnt_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    instr_fields_t       in_fields;
    logic [31:0]         enc_word;
    logic                enc_illegal;
    logic                s2_hold;
    logic                commit;
    logic                s1_adv;
    logic [1:0]          in_flight;
    logic [11:0]         pending;
    logic                accept;

    assign in_fields = '{opcode: in_opcode_i, funct3: in_funct3_i,
                         f30: in_f30_i, rd: in_rd_i, rs1: in_rs1_i,
                         rs2: in_rs2_i, imm: in_imm_i};

    instr_fmt_enc u_fmt_enc (
        .fields_i  (s1_fields_q),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    assign s2_hold   = mem_we_q & ~mem_ready_i;
    assign commit    = mem_we_q & mem_ready_i;
    assign s1_adv    = s1_valid_q & ~s2_hold;
    assign in_flight = {1'b0, s1_valid_q} + {1'b0, mem_we_q};
    // Words already written plus those still in the pipe bound acceptance,
    // so the session can never overshoot DEPTH.
    assign pending   = {1'b0, word_cnt_q} + {10'd0, in_flight};

    // A bundle offered in the same cycle as START would be flushed, so it is
    // refused rather than silently dropped after the handshake.
    assign in_ready_o = (state_q == ST_RUN) & ~start_i & ~(s1_valid_q & s2_hold)
                      & (pending < {1'b0, DEPTH_C});
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        state_d     = state_q;
        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        word_cnt_d  = word_cnt_q;
        full_d      = full_q;
        err_d       = err_q;

        if (start_i) begin
            state_d    = ST_RUN;
            s1_valid_d = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = BASE_ADDR;
            word_cnt_d = '0;
            full_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN:  if (commit && (word_cnt_q + 11'd1) == DEPTH_C) begin
                             state_d = ST_FULL;
                         end
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase

            if (commit) begin
                mem_we_d   = 1'b0;
                mem_addr_d = mem_addr_q + ADDR_W'(4);
                word_cnt_d = word_cnt_q + 11'd1;
                if ((word_cnt_q + 11'd1) == DEPTH_C) begin
                    full_d = 1'b1;
                end
            end

            // S2 refill overrides the commit-clear so a steady stream keeps
            // mem_we high every cycle.
            if (s1_adv) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = enc_word;
                s1_valid_d  = 1'b0;
                if (enc_illegal) begin
                    err_d = 1'b1;
                end
            end

            if (accept) begin
                s1_valid_d  = 1'b1;
                s1_fields_d = in_fields;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            word_cnt_q  <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_valid_q  <= s1_valid_d;
            s1_fields_q <= s1_fields_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            word_cnt_q  <= word_cnt_d;
            full_q      <= full_d;
            err_q       <= err_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign word_cnt_o  = word_cnt_q;
    assign full_o      = full_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed bench for instr_encoder_loader (DEPTH=4 so the FULL boundary is
// reachable). A table of encode vectors is applied one per session, followed
// by hand-written stall, FULL, flush and encode-error sequences. Honours
// ENC_ILLEGAL_CHK_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
`ifdef ENC_ILLEGAL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, in_f30, mem_we, mem_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, mem_wdata;
    logic [15:0] mem_addr;
    logic [10:0] word_cnt;
    logic        full, err;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_opcode_i(in_opcode), .in_funct3_i(in_funct3), .in_f30_i(in_f30),
        .in_rd_i(in_rd), .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_imm_i(in_imm),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .word_cnt_o(word_cnt), .full_o(full), .err_o(err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Completed memory writes as {addr, data}.
    logic [47:0] wq[$];
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) wq.push_back({mem_addr, mem_wdata});
    end

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f30;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_word;
        bit          exp_bad;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f30,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
        in_opcode = op; in_funct3 = f3; in_f30 = f30;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    // Offer the driven bundle; returns at the cycle after acceptance, or
    // with ok=0 once the budget expires.
    task automatic send(input int budget, output bit ok);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok, ok2;
        int n_acc;
        logic [47:0] e;

        vecs[0] = '{7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,         32'h00500093, 1'b0};
        vecs[1] = '{7'b0110111, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,  32'h123452B7, 1'b0};
        vecs[2] = '{7'b1101111, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,         32'h008000EF, 1'b0};
        vecs[3] = '{7'b0000000, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h00000013, 1'b1};
        vecs[4] = '{7'b0010011, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,         32'h40315093, 1'b0};
        vecs[5] = '{7'b0000011, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFFFFF8,  32'hFF812203, 1'b0};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready),  32'd0);
        check("rst_mem_we",   32'(mem_we),    32'd0);
        check("rst_addr",     32'(mem_addr),  32'd0);
        check("rst_wdata",    mem_wdata,      32'd0);
        check("rst_word_cnt", 32'(word_cnt),  32'd0);
        check("rst_full",     32'(full),      32'd0);
        check("rst_err",      32'(err),       32'd0);

        // Encode table: one word per session, exact two-cycle latency.
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start_session();
            drive(vecs[i].op, vecs[i].f3, vecs[i].f30, vecs[i].rd, vecs[i].rs1,
                  vecs[i].rs2, vecs[i].imm);
            send(4, ok);
            check($sformatf("vec%0d_accept", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_we_lat1", i), 32'(mem_we), 32'd0);
            tick();
            check($sformatf("vec%0d_we_lat2", i), 32'(mem_we), 32'd1);
            check($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'd0);
            check($sformatf("vec%0d_word", i), mem_wdata, vecs[i].exp_word);
            tick();
            check($sformatf("vec%0d_cnt", i), 32'(word_cnt), 32'd1);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_bad & CHK));
        end

        // Back-to-back sub/sw/beq with a 3-cycle memory stall.
        start_session();
        mem_ready = 1'b0;
        wq.delete();
        fork
            begin
                drive(7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
                send(8, ok);
                check("stall_acc_sub", 32'(ok), 32'd1);
                drive(7'b0100011, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
                send(8, ok);
                check("stall_acc_sw", 32'(ok), 32'd1);
                drive(7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
                send(12, ok);
                check("stall_acc_beq", 32'(ok), 32'd1);
            end
            begin
                ok2 = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    if (mem_we) begin ok2 = 1'b1; break; end
                    tick();
                end
                check("stall_we_seen", 32'(ok2), 32'd1);
                for (int i = 0; i < 3; i++) begin
                    check("stall_hold_we",    32'(mem_we), 32'd1);
                    check("stall_hold_wdata", mem_wdata,   32'h402081B3);
                    check("stall_hold_addr",  32'(mem_addr), 32'd0);
                    tick();
                end
                mem_ready = 1'b1;
            end
        join
        for (int i = 0; i < 20 && word_cnt != 11'd3; i++) tick();
        check("stall_cnt",   32'(word_cnt), 32'd3);
        check("stall_full",  32'(full), 32'd0);
        check("stall_nwr",   32'(wq.size()), 32'd3);
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            e = wq[i];
            check($sformatf("stall_wr%0d_addr", i), 32'(e[47:32]), 32'(i * 4));
            case (i)
                0: check("stall_wr0_data", e[31:0], 32'h402081B3);
                1: check("stall_wr1_data", e[31:0], 32'h0020A423);
                default: check("stall_wr2_data", e[31:0], 32'hFE208EE3);
            endcase
        end

        // FULL boundary: six bundles offered, only DEPTH accepted.
        start_session();
        wq.delete();
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(7'b0010011, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
            send(6, ok);
            if (ok) n_acc++;
        end
        tick();
        check("full_accepted", 32'(n_acc), 32'd4);
        check("full_cnt",      32'(word_cnt), 32'd4);
        check("full_flag",     32'(full), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_nwr",      32'(wq.size()), 32'd4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            e = wq[i];
            check($sformatf("full_wr%0d_addr", i), 32'(e[47:32]), 32'(i * 4));
        end
        start_session();
        #1;
        check("restart_addr",     32'(mem_addr), 32'd0);
        check("restart_cnt",      32'(word_cnt), 32'd0);
        check("restart_full",     32'(full), 32'd0);
        check("restart_in_ready", 32'(in_ready), 32'd1);

        // START with two words in flight drops both.
        start_session();
        mem_ready = 1'b0;
        wq.delete();
        drive(7'b0010011, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'd7);
        send(4, ok);
        drive(7'b0010011, 3'd0, 1'b0, 5'd8, 5'd0, 5'd0, 32'd8);
        send(4, ok2);
        check("flush_acc", 32'({ok, ok2}), 32'd3);
        check("flush_inflight_we", 32'(mem_we), 32'd1);
        start_session();
        check("flush_we_cleared", 32'(mem_we), 32'd0);
        mem_ready = 1'b1;
        repeat (3) tick();
        check("flush_nwr", 32'(wq.size()), 32'd0);
        check("flush_cnt", 32'(word_cnt), 32'd0);
        drive(7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        send(4, ok);
        tick();
        tick();
        check("flush_next_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) begin
            e = wq[0];
            check("flush_next_addr", 32'(e[47:32]), 32'd0);
            check("flush_next_data", e[31:0], 32'h00500093);
        end

        // Misaligned branch: NOP + sticky ERR with the check option,
        // truncated encoding without it.
        start_session();
        wq.delete();
        drive(7'b1100011, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
        send(4, ok);
        tick();
        tick();
        check("err_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) begin
            e = wq[0];
            check("err_word", e[31:0], CHK ? 32'h00000013 : 32'h00208163);
        end
        check("err_set", 32'(err), 32'(CHK));
        drive(7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        send(4, ok);
        tick();
        tick();
        check("err_sticky", 32'(err), 32'(CHK));
        start_session();
        check("err_cleared", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
